tag_freelist: RTL and testbench

TAG_FREELIST -- requirements
Module: tag_freelist

---
 rtl/tag_freelist.sv | 102 ++++++++++
 tb/tb_tag_freelist.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_freelist.sv
// tag_freelist
// Free list of rename tags for the register alias table. The free tags sit in
// a DEPTH-entry circular buffer. Allocation takes the tag at the head, and a
// free appends the returned tag at the tail. After reset or recover the list
// is full and holds 0..DEPTH-1 in order.
//
// Ports
//   clk          single clock, all state updates on posedge
//   rst          synchronous active-high reset, highest priority
//   alloc_req    rename stage asks for one tag this cycle
//   alloc_valid  a free tag is on alloc_tag (list not empty)
//   alloc_tag    tag at the list head, drives the alias table res_tag
//   free_en      return one tag this cycle
//   free_tag     tag being returned
//   recover      mispredict recovery, refills the list to 0..DEPTH-1
//   count        number of free tags held (0..DEPTH)
//   empty        count == 0
//   full         count == DEPTH
//   overflow     sticky, set by a free attempted while full, cleared by rst only
module tag_freelist #(
  parameter int TAGW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  output logic            alloc_valid,
  output logic [TAGW-1:0] alloc_tag,
  input  logic            free_en,
  input  logic [TAGW-1:0] free_tag,
  input  logic            recover,
  output logic [TAGW:0]   count,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  localparam int DEPTH = 1 << TAGW;
  localparam logic [TAGW:0] DEPTH_CNT = (TAGW+1)'(DEPTH);

  logic [TAGW-1:0] tagBuf_q [DEPTH];
  logic [TAGW-1:0] head_q, head_d;
  logic [TAGW-1:0] tail_q, tail_d;
  logic [TAGW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            doAlloc, doFree;

  // All outputs come from registered state only. A tag freed while the list
  // is empty therefore first shows up on the cycle after the free.
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_CNT);
  assign alloc_valid = !empty;
  assign alloc_tag   = tagBuf_q[head_q];
  assign count       = count_q;
  assign overflow    = overflow_q;

  // Each side is gated only by its own blocking condition. When the list is
  // empty, alloc+free performs only the free. When it is full, alloc+free
  // performs only the alloc. The pointers wrap by natural overflow.
  always_comb begin
    doAlloc    = alloc_req && !empty;
    doFree     = free_en && !full;
    head_d     = doAlloc ? head_q + TAGW'(1) : head_q;
    tail_d     = doFree ? tail_q + TAGW'(1) : tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (free_en && full);
    case ({doAlloc, doFree})
      2'b10:   count_d = count_q - (TAGW+1)'(1);
      2'b01:   count_d = count_q + (TAGW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // rst refills the list and clears overflow. recover refills the list but
  // keeps overflow. Each discards the alloc/free requests of its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tagBuf_q[i] <= TAGW'(i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= DEPTH_CNT;
      overflow_q <= 1'b0;
    end else if (recover) begin
      for (int i = 0; i < DEPTH; i++) begin
        tagBuf_q[i] <= TAGW'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= DEPTH_CNT;
    end else begin
      if (doFree) begin
        tagBuf_q[tail_q] <= free_tag;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_tag_freelist.sv
// tb_tag_freelist
// Directed bench for tag_freelist with TAGW=6 (64 tags). Stimulus pushes the
// tag it expects for each allocation that should be accepted. A monitor checks
// the tag whenever the DUT takes an allocation on the coming edge. Status
// outputs are checked after each step against hand-computed counts.
module tb_tag_freelist;

  localparam int TAGW  = 6;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_req;
  logic            alloc_valid;
  logic [TAGW-1:0] alloc_tag;
  logic            free_en;
  logic [TAGW-1:0] free_tag;
  logic            recover;
  logic [TAGW:0]   count;
  logic            empty;
  logic            full;
  logic            overflow;

  int assertCount = 0;
  int failCount   = 0;
  int expCount;

  logic [TAGW-1:0] expQ[$];
  logic [TAGW-1:0] pendQ[$];

  tag_freelist #(.TAGW(TAGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .free_en     (free_en),
    .free_tag    (free_tag),
    .recover     (recover),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Generic comparison, counted in the summary.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Checks all status outputs for an expected free count and overflow flag.
  task automatic checkStatus(input string name, input int expCnt, input logic expOvf);
    checkOutput({name, "_count"}, 32'(count), 32'(expCnt));
    checkOutput({name, "_empty"}, 32'(empty), 32'(expCnt == 0));
    checkOutput({name, "_full"}, 32'(full), 32'(expCnt == DEPTH));
    checkOutput({name, "_valid"}, 32'(alloc_valid), 32'(expCnt != 0));
    checkOutput({name, "_overflow"}, 32'(overflow), 32'(expOvf));
  endtask

  task automatic expectAlloc(input logic [TAGW-1:0] t);
    expQ.push_back(t);
  endtask

  // Holds the requests for exactly one rising edge and samples 1 time unit later.
  task automatic applyStimulus(input logic a, input logic f, input logic [TAGW-1:0] t, input logic r);
    alloc_req = a;
    free_en   = f;
    free_tag  = t;
    recover   = r;
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    free_en   = 1'b0;
    free_tag  = '0;
    recover   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // The monitor samples on the falling edge. If the DUT will take an
  // allocation on the next rising edge, it pops and compares the expected tag.
  always @(negedge clk) begin
    if (!rst && !recover && alloc_req && alloc_valid) begin
      assertCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpected_alloc actual=%0d expected=none", alloc_tag);
      end else begin
        logic [TAGW-1:0] e;
        e = expQ.pop_front();
        if (alloc_tag !== e) begin
          failCount++;
          $display("[TB] FAIL alloc_tag actual=%0d expected=%0d", alloc_tag, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    alloc_req = 1'b0;
    free_en   = 1'b0;
    free_tag  = '0;
    recover   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset state");
    checkStatus("reset", DEPTH, 1'b0);
    checkOutput("reset_tag", 32'(alloc_tag), 32'd0);

    $display("[TB] free while full sets sticky overflow");
    applyStimulus(1'b0, 1'b1, TAGW'(3), 1'b0);
    checkStatus("free_full", DEPTH, 1'b1);
    checkOutput("free_full_tag", 32'(alloc_tag), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkStatus("recover_keeps_ovf", DEPTH, 1'b1);
    doReset();
    checkStatus("reset_clears_ovf", DEPTH, 1'b0);

    $display("[TB] drain all 64 tags in order");
    for (int i = 0; i < DEPTH; i++) begin
      expectAlloc(TAGW'(i));
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      checkOutput("drain_count", 32'(count), 32'(DEPTH - 1 - i));
    end
    checkStatus("drained", 0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkStatus("alloc_empty_ignored", 0, 1'b0);

    $display("[TB] free with alloc while empty");
    applyStimulus(1'b1, 1'b1, TAGW'(17), 1'b0);
    checkStatus("free_on_empty", 1, 1'b0);
    checkOutput("free_on_empty_tag", 32'(alloc_tag), 32'd17);
    expectAlloc(TAGW'(17));
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkStatus("take17", 0, 1'b0);

    $display("[TB] simultaneous alloc and free at count 10");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, TAGW'(20 + i), 1'b0);
    end
    checkStatus("fill10", 10, 1'b0);
    checkOutput("fill10_tag", 32'(alloc_tag), 32'd20);
    for (int i = 0; i < 3; i++) begin
      expectAlloc(TAGW'(20 + i));
      applyStimulus(1'b1, 1'b1, TAGW'(5), 1'b0);
      checkOutput("simul_count", 32'(count), 32'd10);
    end
    for (int i = 23; i < 30; i++) begin
      expectAlloc(TAGW'(i));
    end
    for (int i = 0; i < 3; i++) begin
      expectAlloc(TAGW'(5));
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
    end
    checkStatus("drain10", 0, 1'b0);

    $display("[TB] recover beats alloc and free");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, TAGW'(40 + i), 1'b0);
    end
    checkStatus("count7", 7, 1'b0);
    applyStimulus(1'b1, 1'b1, TAGW'(50), 1'b1);
    checkStatus("recover", DEPTH, 1'b0);
    checkOutput("recover_tag", 32'(alloc_tag), 32'd0);

    $display("[TB] alloc and free while full");
    expectAlloc(TAGW'(0));
    applyStimulus(1'b1, 1'b1, TAGW'(9), 1'b0);
    checkStatus("full_alloc_free", DEPTH - 1, 1'b1);
    checkOutput("full_alloc_free_tag", 32'(alloc_tag), 32'd1);

    $display("[TB] reset beats in-flight requests");
    rst       = 1'b1;
    alloc_req = 1'b1;
    free_en   = 1'b1;
    free_tag  = TAGW'(12);
    recover   = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    alloc_req = 1'b0;
    free_en   = 1'b0;
    free_tag  = '0;
    recover   = 1'b0;
    checkStatus("reset_midop", DEPTH, 1'b0);
    checkOutput("reset_midop_tag", 32'(alloc_tag), 32'd0);

    $display("[TB] wrap-around");
    expCount = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      expectAlloc(TAGW'(i));
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      expCount--;
      checkOutput("wrap_alloc64_count", 32'(count), 32'(expCount));
    end
    for (int i = 0; i < 40; i++) begin
      pendQ.push_back(TAGW'((i * 7 + 3) % 64));
      applyStimulus(1'b0, 1'b1, TAGW'((i * 7 + 3) % 64), 1'b0);
      expCount++;
      checkOutput("wrap_free40_count", 32'(count), 32'(expCount));
    end
    for (int i = 0; i < 30; i++) begin
      expectAlloc(pendQ.pop_front());
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      expCount--;
      checkOutput("wrap_alloc30a_count", 32'(count), 32'(expCount));
    end
    for (int i = 0; i < 30; i++) begin
      pendQ.push_back(TAGW'((i * 11 + 1) % 64));
      applyStimulus(1'b0, 1'b1, TAGW'((i * 11 + 1) % 64), 1'b0);
      expCount++;
      checkOutput("wrap_free30_count", 32'(count), 32'(expCount));
    end
    for (int i = 0; i < 30; i++) begin
      expectAlloc(pendQ.pop_front());
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      expCount--;
      checkOutput("wrap_alloc30b_count", 32'(count), 32'(expCount));
    end
    checkStatus("wrap_end", 10, 1'b0);

    @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
